// File: rtl/adder_4bit_pkg.sv
// adder_4bit_pkg: shared width, operand/sum types and pipeline latency for adder_4bit.
//   ADDER_4BIT_INREG_EN selects LATENCY: 2 when defined, 1 otherwise.
package adder_4bit_pkg;
  localparam int ADDER_WIDTH = 4;
  typedef logic [ADDER_WIDTH-1:0] operand_t;
  typedef logic [ADDER_WIDTH:0] sum_t;
`ifdef ADDER_4BIT_INREG_EN
  localparam int LATENCY = 2;
`else
  localparam int LATENCY = 1;
`endif
endpackage

// File: rtl/adder_4bit_full_adder.sv
// full_adder: 1-bit full adder cell for the adder_4bit ripple chain.
//   a, b, cin : addend bits and carry-in
//   s, cout   : sum bit and carry-out (majority of a, b, cin)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/adder_4bit.sv
// adder_4bit: registered unsigned ripple-carry adder, ans = A + B with carry in the MSB.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears every register
//   A, B  : WIDTH-bit unsigned operands
//   ans   : WIDTH+1-bit registered sum, ans[WIDTH] is the carry-out
//   ADDER_4BIT_INREG_EN adds an input register stage (latency 2 instead of 1).
module adder_4bit
  import adder_4bit_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH:0]   ans
);
  logic [WIDTH-1:0] a_q, b_q, s;
  logic [WIDTH:0]   c;
`ifdef ADDER_4BIT_INREG_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= A;
      b_q <= B;
    end
`else
  assign a_q = A;
  assign b_q = B;
`endif
  assign c[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a   (a_q[i]),
      .b   (b_q[i]),
      .cin (c[i]),
      .s   (s[i]),
      .cout(c[i+1])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ans <= '0;
    else ans <= {c[WIDTH], s};
endmodule

// File: tb/tb_adder_4bit.sv
// tb_adder_4bit: self-checking bench for adder_4bit against a queue-based latency model.
module tb_adder_4bit;
  import adder_4bit_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  operand_t a_in, b_in;
  sum_t ans;
  int checks = 0;
  int errors = 0;
  int q[$];
  adder_4bit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (a_in),
    .B    (b_in),
    .ans  (ans)
  );
  always #5 clk = ~clk;
  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < LATENCY - 1; i++) q.push_back(0);
  endfunction
  task automatic check(input string tag, input sum_t e);
    checks++;
    assert (ans === e) else begin
      errors++;
      $error("FAIL %s ans=%0d exp=%0d", tag, ans, e);
    end
  endtask
  task automatic cycle(input operand_t a, input operand_t b, input string tag);
    int e;
    a_in = a;
    b_in = b;
    @(posedge clk);
    q.push_back(int'(a) + int'(b));
    e = q.pop_front();
    #1 check(tag, sum_t'(e));
  endtask
  task automatic hold(input operand_t a, input operand_t b, input sum_t e, input string tag);
    repeat (LATENCY) cycle(a, b, {tag, "_pipe"});
    check(tag, e);
  endtask
  task automatic mid_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check(tag, '0);
    #2 rst_n = 1'b1;
    model_reset();
  endtask
  initial begin
    model_reset();
    a_in = 4'hF;
    b_in = 4'hF;
    #1 rst_n = 1'b0;
    #1 check("reset_async", '0);
    @(posedge clk);
    #1 check("reset_hold1", '0);
    @(posedge clk);
    #1 check("reset_hold2", '0);
    #2 rst_n = 1'b1;
    model_reset();
    hold(4'd0, 4'd0, 5'd0, "zero");
    hold(4'd15, 4'd1, 5'b10000, "carry16");
    hold(4'd14, 4'd1, 5'b01111, "nocarry15");
    hold(4'd15, 4'd15, 5'd30, "max30");
    checks++;
    assert (ans[4] === 1'b1) else begin
      errors++;
      $error("FAIL max_carry ans4=%0b exp=1", ans[4]);
    end
    for (int i = 0; i < 512; i++) begin
      cycle(operand_t'(i[3:0]), operand_t'(i[4:1]), "sweep");
      if (i == 200) mid_reset("sweep_rst");
    end
    for (int i = 0; i < 256; i++) cycle(operand_t'(i[3:0]), operand_t'(i[7:4]), "all_pairs");
    for (int i = 0; i < 300; i++) begin
      cycle(operand_t'($urandom_range(15)), operand_t'($urandom_range(15)), "random");
      if (i % 97 == 50) mid_reset("random_rst");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
